// File: rtl/pdm_capture.sv
// PDM microphone capture: generates the mic bit clock, samples the 1-bit stream,
// packs 16 samples MSB-first and writes each word to the selected audio block RAM.
module pdm_capture #(
  parameter int unsigned                  CLK_DIV    = 50,
  parameter int unsigned                  ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0]        MAX_ADDR   = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  record,
  input  logic                  bank_sel,
  input  logic                  microphone,
  output logic                  scaledclk,
  output logic [15:0]           data,
  output logic [ADDR_WIDTH-1:0] memaddr,
  output logic                  block1ena,
  output logic                  block1wea,
  output logic                  block2ena,
  output logic                  block2wea,
  output logic                  donedes,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_div_cnt;
  logic                    r_sclk;
  logic [3:0]              r_bit_cnt;
  logic [15:0]             r_shreg;
  logic [15:0]             r_data;
  logic [ADDR_WIDTH-1:0]   r_memaddr;
  logic [ADDR_WIDTH-1:0]   r_word_count;
  logic                    r_bank;
  logic                    r_b1ena;
  logic                    r_b1wea;
  logic                    r_b2ena;
  logic                    r_b2wea;
  logic                    r_donedes;
  logic                    r_done;
  logic                    w_div_wrap;
  logic                    w_tick;
  logic [15:0]             w_shreg_next;

  assign w_div_wrap   = (r_div_cnt == DIV_LAST);
  assign w_tick       = w_div_wrap && !r_sclk;
  assign w_shreg_next = {r_shreg[14:0], microphone};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_memaddr    <= '0;
      r_word_count <= '0;
      r_bank       <= 1'b0;
      r_b1ena      <= 1'b0;
      r_b1wea      <= 1'b0;
      r_b2ena      <= 1'b0;
      r_b2wea      <= 1'b0;
      r_donedes    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_b1ena   <= 1'b0;
      r_b1wea   <= 1'b0;
      r_b2ena   <= 1'b0;
      r_b2wea   <= 1'b0;
      r_donedes <= 1'b0;
      // Divider free-runs by default; branches entering DONE/IDLE override it to 0.
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_sclk    <= ~r_sclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_sclk    <= 1'b0;
          r_done    <= 1'b0;
          if (record) begin
            r_bank       <= bank_sel;
            r_memaddr    <= '0;
            r_word_count <= '0;
            r_bit_cnt    <= '0;
            r_state      <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_tick) begin
            r_shreg   <= w_shreg_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_tick && (r_bit_cnt == 4'd15)) begin
            r_data    <= w_shreg_next;
            r_b1ena   <= ~r_bank;
            r_b1wea   <= ~r_bank;
            r_b2ena   <= r_bank;
            r_b2wea   <= r_bank;
            r_donedes <= 1'b1;
            r_state   <= S_WRITE;
          end else if (!record) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_WRITE: begin
          if (r_word_count != '1)
            r_word_count <= r_word_count + 1'b1;
          if (r_memaddr == MAX_ADDR) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_memaddr <= r_memaddr + 1'b1;
            r_state   <= S_CAPTURE;
          end
        end
        S_DONE: begin
          r_div_cnt <= '0;
          r_sclk    <= 1'b0;
          if (!record) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign scaledclk  = r_sclk;
  assign data       = r_data;
  assign memaddr    = r_memaddr;
  assign block1ena  = r_b1ena;
  assign block1wea  = r_b1wea;
  assign block2ena  = r_b2ena;
  assign block2wea  = r_b2wea;
  assign donedes    = r_donedes;
  assign done       = r_done;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_pdm_capture.sv
// Self-checking bench for pdm_capture: random PDM streams against a timing/packing
// reference model derived from the tick schedule (CLK_DIV=2, MAX_ADDR=3).
module tb_pdm_capture;
  localparam int CD   = 2;
  localparam int P    = 2 * CD;
  localparam int MAXA = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        record = 1'b0;
  logic        bank_sel = 1'b0;
  logic        microphone = 1'b0;
  logic        scaledclk;
  logic [15:0] data;
  logic [15:0] memaddr;
  logic        block1ena, block1wea, block2ena, block2wea;
  logic        donedes, done;
  logic [15:0] word_count;

  pdm_capture #(.CLK_DIV(CD), .ADDR_WIDTH(16), .MAX_ADDR(16'd3)) dut (
    .clock(clock), .reset(reset), .record(record), .bank_sel(bank_sel),
    .microphone(microphone), .scaledclk(scaledclk), .data(data), .memaddr(memaddr),
    .block1ena(block1ena), .block1wea(block1wea), .block2ena(block2ena),
    .block2wea(block2wea), .donedes(donedes), .done(done), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // {scaledclk[54], data[53:38], memaddr[37:22], strobes[21:17], done[16], word_count[15:0]}
  logic [54:0] w_all;
  assign w_all = {scaledclk, data, memaddr, block1ena, block1wea, block2ena, block2wea,
                  donedes, done, word_count};

  logic        bits [0:127];
  logic [68:0] wq [$];   // {e[31:0], data, addr, strobes}
  int          dq [$];
  logic [54:0] snap_all;
  logic [54:0] fin_all;

  function automatic int tick_e(input int n);
    return CD + n * P;
  endfunction

  function automatic logic [15:0] exp_word(input int w);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[15-i] = bits[16*w + i];
    return v;
  endfunction

  function automatic logic [4:0] exp_strobe(input logic b);
    return b ? 5'b00111 : 5'b11001;
  endfunction

  function automatic logic [68:0] exp_wr(input int w, input logic b);
    return {32'(tick_e(16*w + 15)), exp_word(w), 16'(w), exp_strobe(b)};
  endfunction

  function automatic int n_writes(input int rel_e, input int rst_e, input int end_e);
    int n = 0;
    for (int w = 0; w <= MAXA; w++) begin
      int ew = tick_e(16*w + 15);
      if (ew <= end_e && (rel_e < 0 || ew <= rel_e + 1) && (rst_e < 0 || ew <= rst_e)) n++;
    end
    return n;
  endfunction

  function automatic bit is_last_tick(input int k);
    return (k >= tick_e(15)) && (((k - tick_e(15)) % (16 * P)) == 0);
  endfunction

  // First edge after release where capture is idle between words (not 16th tick, not write).
  function automatic int done_edge(input int rel_e);
    int k = rel_e + 1;
    for (int i = 0; i < 3; i++)
      if (is_last_tick(k) || is_last_tick(k - 1)) k++;
    return k;
  endfunction

  task automatic capture(input logic bank, input int patt, input int rel_e, input int rst_e,
                         input int end_e, input int snap_e, input bit tog);
    for (int i = 0; i < 128; i++)
      bits[i] = (patt == 0) ? 1'b1 : (patt == 1) ? ((i % 2) == 0) : 1'($urandom);
    wq.delete();
    dq.delete();
    @(negedge clock);
    reset = 1'b1;
    record = 1'b1;
    bank_sel = bank;
    @(posedge clock);
    for (int e = 0; e <= end_e; e++) begin
      @(negedge clock);
      if (block1ena | block1wea | block2ena | block2wea | donedes)
        wq.push_back({32'(e), data, memaddr, block1ena, block1wea, block2ena, block2wea, donedes});
      if (done) dq.push_back(e);
      if (e == snap_e) snap_all = w_all;
      fin_all = w_all;
      if (e + 1 >= CD && ((e + 1 - CD) % P) == 0) microphone = bits[(e + 1 - CD) / P];
      else microphone = 1'($urandom);
      if (e == rel_e) record = 1'b0;
      if (e == rst_e) begin reset = 1'b0; record = 1'b0; end
      if (e == rst_e + 2) reset = 1'b1;
      if (tog) bank_sel = 1'($urandom);
    end
    record = 1'b0;
    bank_sel = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset;
    record = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (w_all !== '0) begin
        errors++; $display("FAIL reset_outputs cyc%0d got %h expected 0", i, w_all);
      end
    end
    record = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (w_all !== '0) begin
      errors++; $display("FAIL idle_outputs got %h expected 0", w_all);
    end
  endtask

  task automatic test_ones;
    int n;
    capture(1'b0, 0, -1, -1, 130, -1, 0);
    n = n_writes(-1, -1, 130);
    checks++;
    if (wq.size() !== n) begin
      errors++; $display("FAIL ones_count got %0d expected %0d", wq.size(), n);
    end
    for (int w = 0; w < wq.size() && w < n; w++) begin
      checks++;
      if (wq[w] !== exp_wr(w, 1'b0)) begin
        errors++; $display("FAIL ones_wr%0d got %h expected %h", w, wq[w], exp_wr(w, 1'b0));
      end
    end
  endtask

  task automatic test_alternating;
    int n;
    capture(1'b1, 1, -1, -1, 130, -1, 0);
    n = n_writes(-1, -1, 130);
    checks++;
    if (wq.size() !== n) begin
      errors++; $display("FAIL alt_count got %0d expected %0d", wq.size(), n);
    end
    for (int w = 0; w < wq.size() && w < n; w++) begin
      checks++;
      if (wq[w] !== exp_wr(w, 1'b1)) begin
        errors++; $display("FAIL alt_wr%0d got %h expected %h", w, wq[w], exp_wr(w, 1'b1));
      end
    end
  endtask

  task automatic test_bank_toggle;
    int n;
    logic b;
    b = 1'($urandom);
    capture(b, 2, -1, -1, 130, -1, 1);
    n = n_writes(-1, -1, 130);
    checks++;
    if (wq.size() !== n) begin
      errors++; $display("FAIL tog_count got %0d expected %0d", wq.size(), n);
    end
    for (int w = 0; w < wq.size() && w < n; w++) begin
      checks++;
      if (wq[w] !== exp_wr(w, b)) begin
        errors++; $display("FAIL tog_wr%0d got %h expected %h", w, wq[w], exp_wr(w, b));
      end
    end
  endtask

  task automatic test_full;
    int n;
    logic b;
    b = 1'($urandom);
    capture(b, 2, 270, -1, 271, 270, 0);
    n = n_writes(270, -1, 271);
    checks++;
    if (wq.size() !== n || n !== MAXA + 1) begin
      errors++; $display("FAIL full_count got %0d expected %0d", wq.size(), MAXA + 1);
    end
    for (int w = 0; w < wq.size() && w < n; w++) begin
      checks++;
      if (wq[w] !== exp_wr(w, b)) begin
        errors++; $display("FAIL full_wr%0d got %h expected %h", w, wq[w], exp_wr(w, b));
      end
    end
    checks++;
    if (dq.size() == 0 || dq[0] !== tick_e(16*MAXA + 15) + 1) begin
      errors++; $display("FAIL full_done_start got %0d expected %0d",
                         (dq.size() == 0) ? -1 : dq[0], tick_e(16*MAXA + 15) + 1);
    end
    checks++;
    if ({snap_all[54], snap_all[37:22], snap_all[16], snap_all[15:0]} !==
        {1'b0, 16'(MAXA), 1'b1, 16'(MAXA + 1)}) begin
      errors++; $display("FAIL full_hold got sclk=%b addr=%0d done=%b wc=%0d expected 0/%0d/1/%0d",
                         snap_all[54], snap_all[37:22], snap_all[16], snap_all[15:0], MAXA, MAXA + 1);
    end
    checks++;
    if (fin_all[16] !== 1'b0) begin
      errors++; $display("FAIL full_release_done got %b expected 0", fin_all[16]);
    end
  endtask

  task automatic test_release(input int rel_e, input string nm);
    int n;
    capture(1'b0, 2, rel_e, -1, rel_e + 16, -1, 0);
    n = n_writes(rel_e, -1, rel_e + 16);
    checks++;
    if (wq.size() !== n) begin
      errors++; $display("FAIL %s_count got %0d expected %0d", nm, wq.size(), n);
    end
    for (int w = 0; w < wq.size() && w < n; w++) begin
      checks++;
      if (wq[w] !== exp_wr(w, 1'b0)) begin
        errors++; $display("FAIL %s_wr%0d got %h expected %h", nm, w, wq[w], exp_wr(w, 1'b0));
      end
    end
    checks++;
    if (dq.size() !== 1 || dq[0] !== done_edge(rel_e)) begin
      errors++; $display("FAIL %s_done got n=%0d first=%0d expected n=1 at %0d", nm, dq.size(),
                         (dq.size() == 0) ? -1 : dq[0], done_edge(rel_e));
    end
    checks++;
    if (fin_all[15:0] !== 16'(n)) begin
      errors++; $display("FAIL %s_wc got %0d expected %0d", nm, fin_all[15:0], n);
    end
  endtask

  task automatic test_reset_mid;
    int rst_e;
    logic b;
    rst_e = tick_e(8) - 1;
    capture(1'b0, 2, -1, rst_e, rst_e + 6, rst_e + 1, 0);
    checks++;
    if (snap_all !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h expected 0", snap_all);
    end
    checks++;
    if (wq.size() !== 0) begin
      errors++; $display("FAIL rstmid_writes got %0d expected 0", wq.size());
    end
    b = 1'($urandom);
    capture(b, 2, -1, -1, 70, -1, 0);
    checks++;
    if (wq.size() !== 1 || wq[0] !== exp_wr(0, b)) begin
      errors++; $display("FAIL rerecord_wr0 got n=%0d %h expected %h", wq.size(),
                         (wq.size() == 0) ? 69'h0 : wq[0], exp_wr(0, b));
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_alternating();
    test_bank_toggle();
    test_full();
    test_release(tick_e(25) + 1, "release");
    test_release(tick_e(15) - 1, "coincide");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_capture.md
Name: pdm_capture

Overview:
- Record-path front end of the voice recorder.
- Generates the microphone bit clock and samples the 1-bit PDM microphone stream.
- Packs the samples MSB-first into 16-bit words and writes each word into one of the two audio block RAMs at an incrementing address.
- Sits between the microphone pins and the memory blocks; the playback serializer later reads the same RAMs.

Parameters:
- CLK_DIV, 50, system clocks per half period of scaledclk (mic clock = clock/(2*CLK_DIV)); legal range 2 or more.
- ADDR_WIDTH, 16, width of memaddr and word_count.
- MAX_ADDR, 16'hFFFF, last writable word address; the buffer is full after writing here.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- record  in  1  level; high requests capture.
- bank_sel  in  1  0 selects block1, 1 selects block2; sampled only at capture start.
- microphone  in  1  PDM data from the mic.
- scaledclk  out  1  mic bit clock.
- data  out  16  word to write to RAM.
- memaddr  out  ADDR_WIDTH  RAM write address.
- block1ena  out  1  block1 enable.
- block1wea  out  1  block1 write enable.
- block2ena  out  1  block2 enable.
- block2wea  out  1  block2 write enable.
- donedes  out  1  1-cycle pulse, coincident with each write strobe.
- done  out  1  capture finished (see DONE state).
- word_count  out  ADDR_WIDTH  number of words written in the last or current capture.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE; divider, bit counter and shift register cleared.
  - Outputs: scaledclk=0, data=0, memaddr=0, all ena/wea=0, donedes=0, done=0, word_count=0.
  - Takes effect at that edge regardless of state; a partial word is discarded and no write is issued.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps. scaledclk toggles when div_cnt==CLK_DIV-1.
  - sample_tick is an internal 1-cycle pulse on the cycle where scaledclk toggles 0->1; microphone is sampled on that edge.
  - Divider is held at 0 (scaledclk=0) in IDLE and DONE and runs freely in CAPTURE and WRITE.
  - First sample_tick comes CLK_DIV cycles after entering CAPTURE; ticks then repeat every 2*CLK_DIV cycles.
- State IDLE:
  - If record==1: latch bank_sel; memaddr=0, word_count=0, bit_cnt=0; go to CAPTURE.
- State CAPTURE:
  - On sample_tick: shreg = {shreg[14:0], microphone}; bit_cnt++.
  - On the tick where bit_cnt==15 (16th bit): next state WRITE, bit_cnt wraps to 0.
  - If record==0 and no 16th-bit tick on this cycle: discard the partial word and go to DONE.
- State WRITE (exactly 1 cycle):
  - data = completed shreg (registered on entry).
  - Selected bank ena=wea=1; the other bank stays 0. donedes=1.
  - Latency: write strobe is 1 cycle after the 16th sample_tick.
  - Next cycle: word_count++ (saturating at MAX_ADDR+1).
  - If memaddr==MAX_ADDR: memaddr holds and state goes to DONE. Otherwise memaddr++ and state goes to CAPTURE.
  - record==0 during WRITE does not cancel the write; it is honoured in CAPTURE on the next cycle.
- State DONE:
  - done=1; no writes; data and memaddr hold.
  - When record==0, go to IDLE next cycle. Stopping by release therefore gives a 1-cycle done; a full buffer holds done until record is released.
- word_count, data and memaddr hold their values through IDLE until the next capture starts.
- bank_sel changes after capture start have no effect.
- memaddr never wraps.
- Simultaneous events:
  - record and reset low together: reset wins.
  - 16th tick coinciding with record falling: the word is still written.

Test Plan (CLK_DIV=2, so one sample_tick every 4 clocks):
- Reset low 3 cycles, then record=1, bank_sel=0, microphone=1 constant -> first write after 16 ticks: data=16'hFFFF, memaddr=0, block1ena=block1wea=1, donedes high exactly 1 cycle; second write at memaddr=1.
- microphone alternating 1,0 per tick starting with 1 -> data=16'hAAAA; with bank_sel=1 at start -> only block2ena/wea pulse, block1 signals stay 0.
- MAX_ADDR=3, record held high -> exactly 4 writes at addresses 0..3; then done=1 held, word_count=4, scaledclk=0; release record -> IDLE next cycle, done=0.
- Release record after 10 ticks of the second word -> no second write; word_count=1; done high for 1 cycle.
- Reset low during bit 8 of a word -> next edge all outputs 0, no write strobe; re-record starts at memaddr=0.
- Toggle bank_sel mid-capture -> writes stay on the bank latched at start.
